des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Iterative DES key schedule that turns a 64-bit key into the sixteen 48-bit round subkeys, one per accepted handshake. It sits directly upstream of the round function's key-mixing XOR, whose result feeds the eight S-box lookups (s1..s8). It supports encrypt order (K1..K16) and decrypt order (K16..K1).

## Interface
Parameters: none.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous, active-low
- key_in  input  64  DES key; key_in[63] is DES bit 1, key_in[0] is DES bit 64 (parity bits included)
- key_load  input  1  start request; sampled with key_in and decrypt
- decrypt  input  1  1 = emit K16 first, 0 = emit K1 first
- subkey_out  output  48  current subkey; subkey_out[47] is PC-2 output bit 1
- subkey_valid  output  1  subkey_out holds a valid subkey
- subkey_ready  input  1  downstream accepts subkey this cycle
- round_idx  output  4  schedule position of subkey_out, 0..15 (0 = first emitted)
- busy  output  1  schedule in progress
- done  output  1  one-cycle pulse after 16th subkey accepted
- parity_err  output  1  one-cycle pulse on parity-rejected load (see Configuration)

## Operation
- States: IDLE, RUN.
- IDLE, key_load=1: C,D (28 b each) <= PC-1(key_in); direction latched; go RUN.
- Encrypt rotation amounts per round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (left rotate). Subkey r = PC-2(C_r,D_r).
- Decrypt: first subkey = PC-2(C0,D0) (= K16, since total rotation is 28). Subsequent right rotates are 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, giving K15..K1.
- Handshake: transfer when subkey_valid && subkey_ready. On transfer, C/D advance, round_idx increments and the next subkey is registered.
- Without a transfer, subkey_out and round_idx hold. Downstream may stall indefinitely.
- After transfer at round_idx=15: subkey_valid<=0, busy<=0, done<=1 for one cycle, go IDLE.
- key_load while busy is ignored; latched key and direction are unaffected.
- In IDLE, subkey_out holds its last value. Consumers must qualify it with subkey_valid.
- Subkeys depend only on PC-1/PC-2 bit selection; parity bits (DES bits 8,16,...,64) never reach a subkey.

## Timing
- Reset (async assert, sync release): state IDLE, C=D=0, subkey_out=0, subkey_valid=0, round_idx=0, busy=0, done=0, parity_err=0.
- key_load accepted at edge T: busy=1 and subkey_valid=1 with round_idx=0 after T (first subkey latency 1 cycle).
- Next subkey is visible in the cycle after each transfer. With subkey_ready held high, 16 subkeys arrive on 16 consecutive cycles.
- done pulses in the cycle after the final transfer. key_load is accepted again in that same cycle (busy=0).
- rst_n low mid-schedule aborts immediately to reset values; no done pulse.

## Configuration
- DES_KEY_PARITY_CHECK_EN defined:
  - on key_load in IDLE, each key byte must have odd parity;
  - on failure: parity_err=1 for one cycle after the edge, state stays IDLE, no subkeys, busy stays 0.
- Undefined: parity ignored, every load is accepted, parity_err tied 0.

## Test plan
- Encrypt, key 133457799BBCDFF1, subkey_ready=1 -> round_idx 0: 1B02EFFC7072; idx 1: 79AED9DBC9E5; idx 15: CB3D8B0E17F5; done pulses one cycle after idx 15; 16 consecutive valid cycles.
- Decrypt, same key -> idx 0: CB3D8B0E17F5; idx 14: 79AED9DBC9E5; idx 15: 1B02EFFC7072.
- Backpressure: subkey_ready low for 5 cycles at idx 3 -> subkey_out and round_idx stable; resumes with idx 4 value.
- key_load with a different key at idx 7 -> ignored; remaining encrypt subkeys still match 133457799BBCDFF1.
- rst_n low at idx 9 -> all outputs return to reset values within the same cycle; a new load restarts at idx 0.
- With DES_KEY_PARITY_CHECK_EN, key 133457799BBCDFF0 -> parity_err pulse, busy=0, no subkey_valid. Key 133457799BBCDFF1 -> accepted normally.

Source files
------------

// File: rtl/des_key_if.sv
// des_key_if: load / subkey handshake bundle for the DES key schedule.
// The master side loads keys and consumes subkeys; the slave side is the schedule.
interface des_key_if;
  logic [63:0] key_in;
  logic        key_load;
  logic        decrypt;
  logic [47:0] subkey_out;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        parity_err;

  modport master (
    output key_in, key_load, decrypt, subkey_ready,
    input  subkey_out, subkey_valid, round_idx, busy, done, parity_err
  );

  modport slave (
    input  key_in, key_load, decrypt, subkey_ready,
    output subkey_out, subkey_valid, round_idx, busy, done, parity_err
  );
endinterface

// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES key schedule producing the sixteen 48-bit
// round subkeys, one per accepted handshake, in encrypt (K1..K16) or decrypt
// (K16..K1) order.
// Optional feature macro: DES_KEY_PARITY_CHECK_EN -- when defined, a load whose
// key bytes do not all have odd parity is rejected with a parity_err pulse.
module des_key_schedule (
  input  logic          clk,
  input  logic          rst_n,
  des_key_if.slave      bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [55:0] cd;          // {C, D} matching the subkey currently presented
  logic        dir_dec;     // latched direction of the running schedule
  logic [47:0] subkey;
  logic        valid;
  logic [3:0]  idx;
  logic        busy_q;
  logic        done_q;
  logic        parity_err_q;

  logic        load_ok;
  logic [55:0] load_pc1;
  logic [55:0] load_cd;
  logic [55:0] cd_next;
  logic [4:0]  enc_round;
  logic [4:0]  dec_round;

  // Permuted choice 1: DES bit n of the key lives at key[64-n].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    pc1 = {k[64-57], k[64-49], k[64-41], k[64-33], k[64-25], k[64-17], k[64-9],
           k[64-1],  k[64-58], k[64-50], k[64-42], k[64-34], k[64-26], k[64-18],
           k[64-10], k[64-2],  k[64-59], k[64-51], k[64-43], k[64-35], k[64-27],
           k[64-19], k[64-11], k[64-3],  k[64-60], k[64-52], k[64-44], k[64-36],
           k[64-63], k[64-55], k[64-47], k[64-39], k[64-31], k[64-23], k[64-15],
           k[64-7],  k[64-62], k[64-54], k[64-46], k[64-38], k[64-30], k[64-22],
           k[64-14], k[64-6],  k[64-61], k[64-53], k[64-45], k[64-37], k[64-29],
           k[64-21], k[64-13], k[64-5],  k[64-28], k[64-20], k[64-12], k[64-4]};
  endfunction

  // Permuted choice 2: bit n of {C, D} lives at cd[56-n].
  function automatic logic [47:0] pc2(input logic [55:0] c_d);
    pc2 = {c_d[56-14], c_d[56-17], c_d[56-11], c_d[56-24], c_d[56-1],  c_d[56-5],
           c_d[56-3],  c_d[56-28], c_d[56-15], c_d[56-6],  c_d[56-21], c_d[56-10],
           c_d[56-23], c_d[56-19], c_d[56-12], c_d[56-4],  c_d[56-26], c_d[56-8],
           c_d[56-16], c_d[56-7],  c_d[56-27], c_d[56-20], c_d[56-13], c_d[56-2],
           c_d[56-41], c_d[56-52], c_d[56-31], c_d[56-37], c_d[56-47], c_d[56-55],
           c_d[56-30], c_d[56-40], c_d[56-51], c_d[56-45], c_d[56-33], c_d[56-48],
           c_d[56-44], c_d[56-49], c_d[56-39], c_d[56-56], c_d[56-34], c_d[56-53],
           c_d[56-46], c_d[56-42], c_d[56-50], c_d[56-36], c_d[56-29], c_d[56-32]};
  endfunction

  // Left-rotate both 28-bit halves by one or two positions.
  function automatic logic [55:0] rot_left(input logic [55:0] c_d, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = c_d[55:28];
    d = c_d[27:0];
    if (two) rot_left = {c[25:0], c[27:26], d[25:0], d[27:26]};
    else     rot_left = {c[26:0], c[27],    d[26:0], d[27]};
  endfunction

  // Right-rotate both 28-bit halves by one or two positions.
  function automatic logic [55:0] rot_right(input logic [55:0] c_d, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = c_d[55:28];
    d = c_d[27:0];
    if (two) rot_right = {c[1:0], c[27:2], d[1:0], d[27:2]};
    else     rot_right = {c[0],   c[27:1], d[0],   d[27:1]};
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
  function automatic logic single_shift(input logic [4:0] r);
    single_shift = (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
  endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
  // Every key byte must carry odd parity.
  function automatic logic odd_parity_ok(input logic [63:0] k);
    odd_parity_ok = (^k[63:56]) & (^k[55:48]) & (^k[47:40]) & (^k[39:32]) &
                    (^k[31:24]) & (^k[23:16]) & (^k[15:8])  & (^k[7:0]);
  endfunction

  assign load_ok = odd_parity_ok(bus.key_in);
`else
  // Parity bits are never selected by PC-1; gathered here only so they are
  // visibly consumed when the parity check is compiled out.
  logic unused_parity_bits;
  assign unused_parity_bits = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40],
                                bus.key_in[32], bus.key_in[24], bus.key_in[16],
                                bus.key_in[8],  bus.key_in[0]};
  assign load_ok = 1'b1;
`endif

  // Next {C, D}: for the load, and for advancing after a transfer. Encrypt
  // moves from round idx+1 to idx+2; decrypt undoes the rotation of round 16-idx.
  always_comb begin
    load_pc1  = pc1(bus.key_in);
    load_cd   = bus.decrypt ? load_pc1 : rot_left(load_pc1, 1'b0);
    enc_round = {1'b0, idx} + 5'd2;
    dec_round = 5'd16 - {1'b0, idx};
    if (dir_dec) cd_next = rot_right(cd, !single_shift(dec_round));
    else         cd_next = rot_left(cd, !single_shift(enc_round));
  end

  // Control FSM with registered outputs: load, handshake advance, completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cd           <= '0;
      dir_dec      <= 1'b0;
      subkey       <= '0;
      valid        <= 1'b0;
      idx          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_load) begin
            if (load_ok) begin
              dir_dec <= bus.decrypt;
              cd      <= load_cd;
              subkey  <= pc2(load_cd);
              valid   <= 1'b1;
              busy_q  <= 1'b1;
              idx     <= '0;
              state   <= RUN;
            end else begin
              parity_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // A key_load here is deliberately ignored.
          if (valid && bus.subkey_ready) begin
            if (idx == 4'd15) begin
              valid  <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              cd     <= cd_next;
              subkey <= pc2(cd_next);
              idx    <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.subkey_out   = subkey;
  assign bus.subkey_valid = valid;
  assign bus.round_idx    = idx;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.parity_err   = parity_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed, table-driven bench for des_key_schedule.
module tb_des_key_schedule;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [47:0] got [16];

  des_key_if bus();

  des_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,
                                23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,
                                44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Reference: subkey emitted at position pos, from the cumulative rotation
  // of PC-1(key) up to the corresponding round.
  function automatic logic [47:0] ref_key(input logic [63:0] k, input logic dec, input int pos);
    logic [63:0] t;
    logic [55:0] t2;
    logic [55:0] c_d;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] s;
    int r;
    int n;
    c_d = '0;
    for (int i = 0; i < 56; i++) begin
      t   = k >> (64 - PC1_T[i]);
      c_d = {c_d[54:0], t[0]};
    end
    c = c_d[55:28];
    d = c_d[27:0];
    r = dec ? (16 - pos) : (pos + 1);
    n = 0;
    for (int j = 0; j < r; j++) n += SH_T[j];
    for (int j = 0; j < n; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    c_d = {c, d};
    s = '0;
    for (int i = 0; i < 48; i++) begin
      t2 = c_d >> (56 - PC2_T[i]);
      s  = {s[46:0], t2[0]};
    end
    return s;
  endfunction

  typedef struct {
    string       name;
    logic [63:0] key;
    logic        dec;
    int          pos;
    logic [47:0] expv;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " subkey_out"},   64'(bus.subkey_out),   64'd0);
    check({tag, " subkey_valid"}, 64'(bus.subkey_valid), 64'd0);
    check({tag, " round_idx"},    64'(bus.round_idx),    64'd0);
    check({tag, " busy"},         64'(bus.busy),         64'd0);
    check({tag, " done"},         64'(bus.done),         64'd0);
    check({tag, " parity_err"},   64'(bus.parity_err),   64'd0);
  endtask

  // Present a load for one cycle; afterwards position 0 must be visible.
  task automatic start(input logic [63:0] k, input logic dec);
    bus.key_in   = k;
    bus.decrypt  = dec;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
  endtask

  // Consume positions from..15 with ready high; ends in the done cycle.
  task automatic drain(input logic [63:0] k, input logic dec, input int from, input string tag);
    bus.subkey_ready = 1'b1;
    for (int p = from; p < 16; p++) begin
      check($sformatf("%s valid@%0d", tag, p), 64'(bus.subkey_valid), 64'd1);
      check($sformatf("%s busy@%0d", tag, p),  64'(bus.busy),         64'd1);
      check($sformatf("%s idx@%0d", tag, p),   64'(bus.round_idx),    64'(p));
      check($sformatf("%s key@%0d", tag, p),   64'(bus.subkey_out),   64'(ref_key(k, dec, p)));
      got[p] = bus.subkey_out;
      tick();
    end
    check({tag, " done pulse"}, 64'(bus.done),         64'd1);
    check({tag, " busy end"},   64'(bus.busy),         64'd0);
    check({tag, " valid end"},  64'(bus.subkey_valid), 64'd0);
  endtask

  initial begin
    bus.key_in       = '0;
    bus.key_load     = 1'b0;
    bus.decrypt      = 1'b0;
    bus.subkey_ready = 1'b0;

    vecs[0] = '{"enc idx0",  KEY_A, 1'b0, 0,  48'h1B02EFFC7072};
    vecs[1] = '{"enc idx1",  KEY_A, 1'b0, 1,  48'h79AED9DBC9E5};
    vecs[2] = '{"enc idx15", KEY_A, 1'b0, 15, 48'hCB3D8B0E17F5};
    vecs[3] = '{"dec idx0",  KEY_A, 1'b1, 0,  48'hCB3D8B0E17F5};
    vecs[4] = '{"dec idx14", KEY_A, 1'b1, 14, 48'h79AED9DBC9E5};
    vecs[5] = '{"dec idx15", KEY_A, 1'b1, 15, 48'h1B02EFFC7072};

    // Reset state
    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("post reset");

    // Table-driven full schedules
    for (int v = 0; v < 6; v++) begin
      start(vecs[v].key, vecs[v].dec);
      drain(vecs[v].key, vecs[v].dec, 0, vecs[v].name);
      check(vecs[v].name, 64'(got[vecs[v].pos]), 64'(vecs[v].expv));
      tick();
      check({vecs[v].name, " done clear"}, 64'(bus.done), 64'd0);
      check({vecs[v].name, " idle key hold"}, 64'(bus.subkey_out), 64'(got[15]));
    end

    // Back-to-back: load accepted in the done cycle
    start(KEY_B, 1'b0);
    drain(KEY_B, 1'b0, 0, "b2b first");
    start(KEY_A, 1'b1);
    drain(KEY_A, 1'b1, 0, "b2b second");
    tick();

    // Backpressure: stall 5 cycles at idx 3
    start(KEY_A, 1'b0);
    bus.subkey_ready = 1'b1;
    repeat (3) tick();
    bus.subkey_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("stall idx c%0d", s), 64'(bus.round_idx),  64'd3);
      check($sformatf("stall key c%0d", s), 64'(bus.subkey_out), 64'(ref_key(KEY_A, 1'b0, 3)));
    end
    bus.subkey_ready = 1'b1;
    tick();
    drain(KEY_A, 1'b0, 4, "after stall");
    tick();

    // key_load while busy at idx 7 is ignored
    start(KEY_A, 1'b0);
    bus.subkey_ready = 1'b1;
    repeat (7) tick();
    check("idx before ignored load", 64'(bus.round_idx), 64'd7);
    bus.key_in   = KEY_B;
    bus.decrypt  = 1'b1;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    drain(KEY_A, 1'b0, 8, "ignored load");
    tick();

    // Asynchronous reset at idx 9 aborts; a new load restarts at idx 0
    start(KEY_A, 1'b0);
    bus.subkey_ready = 1'b1;
    repeat (9) tick();
    check("idx before abort", 64'(bus.round_idx), 64'd9);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    check_reset_outputs("abort hold");
    rst_n = 1'b1;
    tick();
    check("no done after abort", 64'(bus.done), 64'd0);
    start(KEY_A, 1'b0);
    drain(KEY_A, 1'b0, 0, "restart");
    tick();

    // Bad-parity key
    start(KEY_BAD, 1'b0);
`ifdef DES_KEY_PARITY_CHECK_EN
    check("bad parity err",   64'(bus.parity_err),   64'd1);
    check("bad parity busy",  64'(bus.busy),         64'd0);
    check("bad parity valid", 64'(bus.subkey_valid), 64'd0);
    tick();
    check("bad parity err clear", 64'(bus.parity_err),   64'd0);
    check("bad parity no valid",  64'(bus.subkey_valid), 64'd0);
    start(KEY_A, 1'b0);
    check("good parity err", 64'(bus.parity_err), 64'd0);
    drain(KEY_A, 1'b0, 0, "good parity");
`else
    check("parity ignored err", 64'(bus.parity_err), 64'd0);
    drain(KEY_A, 1'b0, 0, "parity ignored");
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
